// File: rtl/handshake_pkg.sv
// rtl/handshake_pkg.sv - width helpers shared by the handshake blocks
package handshake_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Index/pointer width: a single input still needs a one-bit index port.
  function automatic int idx_width(input int size);
    return (clog2(size) < 1) ? 1 : clog2(size);
  endfunction

  function automatic bit idx_width_ok(input int size, input int index_w);
    return index_w >= idx_width(size);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - stateless one-hot arbiter; round-robin from ptr, or fixed
// priority when CMERGE_FIXED_PRIORITY_EN is defined
module rr_arbiter
  import handshake_pkg::*;
#(
  parameter int SIZE  = 2,
  parameter int PTR_W = idx_width(SIZE)
) (
  input  logic [SIZE-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [SIZE-1:0]  grant
);

  logic found;

`ifdef CMERGE_FIXED_PRIORITY_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      if (req[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`else
  int idx;

  // Scan from ptr upward, wrapping past SIZE-1 back to 0.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < SIZE; k++) begin
      idx = (int'(ptr) + k) % SIZE;
      if (req[idx] && !found) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/cmerge_rr.sv
// rtl/cmerge_rr.sv - elastic control-merge with one registered slot and eager
// data/index fork; CMERGE_FIXED_PRIORITY_EN selects fixed priority arbitration
module cmerge_rr
  import handshake_pkg::*;
#(
  parameter int SIZE       = 2,
  parameter int DATA_TYPE  = 32,
  parameter int INDEX_TYPE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SIZE*DATA_TYPE-1:0] ins,
  input  logic [SIZE-1:0]           ins_valid,
  output logic [SIZE-1:0]           ins_ready,
  output logic [DATA_TYPE-1:0]      outs,
  output logic                      outs_valid,
  input  logic                      outs_ready,
  output logic [INDEX_TYPE-1:0]     index,
  output logic                      index_valid,
  input  logic                      index_ready
);

  localparam int IDX_W = idx_width(SIZE);

  logic                  full_q, full_d;
  logic                  sent_outs_q, sent_outs_d;
  logic                  sent_index_q, sent_index_d;
  logic [DATA_TYPE-1:0]  outs_q, outs_d;
  logic [INDEX_TYPE-1:0] index_q, index_d;

  logic [SIZE-1:0]       grant;
  logic [IDX_W-1:0]      grant_idx;
  logic [DATA_TYPE-1:0]  grant_data;
  logic [IDX_W-1:0]      arb_ptr;
  logic                  done_outs, done_index, slot_free, accept;

  assign outs_valid  = full_q & ~sent_outs_q;
  assign index_valid = full_q & ~sent_index_q;
  assign outs        = outs_q;
  assign index       = index_q;

  assign done_outs  = sent_outs_q  | (outs_valid  & outs_ready);
  assign done_index = sent_index_q | (index_valid & index_ready);
  assign slot_free  = ~full_q | (done_outs & done_index);

  assign ins_ready = grant & {SIZE{slot_free}};
  assign accept    = slot_free & (|(grant & ins_valid));

  rr_arbiter #(
    .SIZE  (SIZE),
    .PTR_W (IDX_W)
  ) u_arb (
    .req   (ins_valid),
    .ptr   (arb_ptr),
    .grant (grant)
  );

  always_comb begin
    grant_idx  = '0;
    grant_data = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (grant[i]) begin
        grant_idx  = IDX_W'(i);
        grant_data = ins[i*DATA_TYPE +: DATA_TYPE];
      end
    end
  end

  // Accept wins over drain: a draining slot is refilled in the same cycle.
  always_comb begin
    full_d       = full_q;
    sent_outs_d  = sent_outs_q;
    sent_index_d = sent_index_q;
    outs_d       = outs_q;
    index_d      = index_q;
    if (accept) begin
      outs_d       = grant_data;
      index_d      = INDEX_TYPE'(grant_idx);
      full_d       = 1'b1;
      sent_outs_d  = 1'b0;
      sent_index_d = 1'b0;
    end else if (done_outs && done_index) begin
      full_d       = 1'b0;
      sent_outs_d  = 1'b0;
      sent_index_d = 1'b0;
    end else begin
      sent_outs_d  = done_outs;
      sent_index_d = done_index;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q       <= 1'b0;
      sent_outs_q  <= 1'b0;
      sent_index_q <= 1'b0;
      outs_q       <= '0;
      index_q      <= '0;
    end else begin
      full_q       <= full_d;
      sent_outs_q  <= sent_outs_d;
      sent_index_q <= sent_index_d;
      outs_q       <= outs_d;
      index_q      <= index_d;
    end
  end

`ifdef CMERGE_FIXED_PRIORITY_EN
  assign arb_ptr = '0;
`else
  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (grant_idx == IDX_W'(SIZE - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign arb_ptr = ptr_q;
`endif

endmodule
